gate_response_misr: RTL and testbench

- Downstream response compactor for the 13-input / 10-output gate-model netlists in the gate library.
- Consumes one 10-bit output vector of the device under test per accepted beat and folds it into a multiple-input signature register (MISR).
- Counts accepted patterns and, after a programmed number, compares the final signature against an expected value.
- Sits between the gate model's outputs and the simulator's test/result bus; turns a combinational netlist run into a single pass/fail plus signature.

---
 rtl/gate_response_misr.sv | 126 ++++++++++++
 tb/tb_gate_response_misr.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/gate_response_misr.sv
// gate_response_misr: folds gate-model response vectors into a MISR over a
// programmed number of patterns, then compares against a golden signature.
// Optional macro MISR_XMASK_EN adds resp_mask to zero selected response bits.
module gate_response_misr #(
  parameter int              RESP_W = 10,
  parameter int              SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = 16'h0000,
  parameter int              CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_patterns,
  input  logic [SIG_W-1:0]  expected_sig,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp,
`ifdef MISR_XMASK_EN
  input  logic [RESP_W-1:0] resp_mask,
`endif
  output logic              resp_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [RESP_W-1:0] resp_eff;
  logic [SIG_W-1:0]  misr_next;
  logic [CNT_W-1:0]  cnt_inc;
  logic              accept;

  // Masked bits are forced to 0 so unknown outputs never reach the signature.
`ifdef MISR_XMASK_EN
  assign resp_eff = resp & ~resp_mask;
`else
  assign resp_eff = resp;
`endif

  assign resp_ready = (state_q == S_RUN);
  assign accept     = resp_valid && resp_ready;
  assign cnt_inc    = cnt_q + CNT_W'(1);

  // One MISR step: shift left, fold POLY back in when the MSB drops out, XOR response.
  always_comb begin
    misr_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ SIG_W'(resp_eff);
  end

  // Next-state and datapath decode; registered status outputs follow the next state.
  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    pass_d   = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sig_d    = SEED;
          cnt_d    = '0;
          pass_d   = 1'b0;
          target_d = num_patterns;
          state_d  = (num_patterns == '0) ? S_CHECK : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          sig_d = misr_next;
          cnt_d = cnt_inc;
          if (cnt_inc == target_q) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        pass_d  = (sig_q == expected_sig);
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  // All state flops; reset discards any partial signature.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sig_q    <= SEED;
      cnt_q    <= '0;
      target_q <= '0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_gate_response_misr.sv
// tb_gate_response_misr: directed and randomized runs against a behavioural
// MISR model; checks handshake, per-beat signature/count, pass and reset.
module tb_gate_response_misr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_patterns = '0;
  logic [15:0] expected_sig = '0;
  logic        resp_valid = 1'b0;
  logic [9:0]  resp = '0;
  logic [9:0]  mask_v = '0;
  logic        resp_ready, busy, done, pass;
  logic [15:0] signature, count;

  int checks = 0;
  int errors = 0;

  // Directed response values and valid patterns; empty means random.
  int dq[$];
  int vpat[$];

  always #5 clk = ~clk;

  gate_response_misr dut (
    .clk(clk), .rst(rst), .start(start), .num_patterns(num_patterns),
    .expected_sig(expected_sig), .resp_valid(resp_valid), .resp(resp),
`ifdef MISR_XMASK_EN
    .resp_mask(mask_v),
`endif
    .resp_ready(resp_ready), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: signature as a 16-bit value shifted as an integer, reduced by 0x11021.
  function automatic int model_step(input int sig, input int r);
    int t;
    t = sig * 2;
    if (t >= 65536) t = (t - 65536) ^ 16'h1021;
    return t ^ r;
  endfunction

  // One complete run. mode 0: golden is exp; mode 1: golden chosen in CHECK.
  task automatic do_run(input int n, input int pct, input int mode,
                        input int exp, input bit ign_start);
    int msig, mcnt, budget, v, r, gold;
    msig = 0; mcnt = 0; budget = 0;
    @(negedge clk);
    start = 1'b1; num_patterns = 16'(n);
    expected_sig = (mode == 0) ? 16'(exp) : 16'($urandom);
    @(negedge clk);
    start = 1'b0;
    chk("start_sig", signature, 32'h0);
    chk("start_cnt", count, 32'h0);
    chk("start_done", done, 32'h0);
    if (n != 0) chk("start_pass", pass, 32'h0);
    while (mcnt < n) begin
      if (budget > 400) begin chk("run_timeout", 32'(mcnt), 32'(n)); break; end
      budget++;
      chk("run_ready", resp_ready, 32'h1);
      chk("run_busy", busy, 32'h1);
      v = (vpat.size() != 0) ? vpat.pop_front() : int'($urandom_range(99) < pct);
      r = (v != 0 && dq.size() != 0) ? dq.pop_front() : int'($urandom_range(1023));
      resp_valid = v[0];
      resp = 10'(r);
      start = ign_start && ($urandom_range(3) == 0);
      num_patterns = 16'($urandom_range(0, 3));
      @(negedge clk);
      if (v != 0) begin
        msig = model_step(msig, r & ~int'(mask_v));
        mcnt++;
      end
      chk("run_sig", signature, 32'(msig));
      chk("run_cnt", count, 32'(mcnt));
    end
    resp_valid = 1'b0;
    start = 1'b0;
    chk("chk_ready", resp_ready, 32'h0);
    chk("chk_busy", busy, 32'h1);
    chk("chk_done", done, 32'h0);
    if (mode == 0) gold = exp;
    else gold = ($urandom_range(1) == 1) ? msig : (msig ^ int'($urandom_range(1, 65535)));
    expected_sig = 16'(gold);
    @(negedge clk);
    expected_sig = ~expected_sig;
    chk("done_done", done, 32'h1);
    chk("done_busy", busy, 32'h0);
    chk("done_pass", pass, 32'(msig == gold));
    chk("done_sig", signature, 32'(msig));
    @(negedge clk);
    chk("hold_done", done, 32'h1);
    chk("hold_pass", pass, 32'(msig == gold));
    chk("hold_sig", signature, 32'(msig));
  endtask

  initial begin
    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_sig", signature, 32'h0);
    chk("rst_cnt", count, 32'h0);
    chk("rst_ready", resp_ready, 32'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_done", done, 32'h0);
    chk("rst_pass", pass, 32'h0);
    rst = 1'b0;

    // Single pattern.
    vpat = '{1}; dq = '{1};
    do_run(1, 100, 0, 16'h0001, 1'b0);

    // Two patterns, then rerun expecting a failing compare.
    vpat = '{1, 1}; dq = '{1, 2};
    do_run(2, 100, 0, 16'h0000, 1'b0);
    vpat = '{1, 1}; dq = '{1, 2};
    do_run(2, 100, 0, 16'h0003, 1'b0);

    // Feedback path: walk a bit into the MSB, then one more shift folds POLY in.
    vpat = '{1, 1, 1, 1, 1, 1, 1, 1}; dq = '{16'h200, 0, 0, 0, 0, 0, 0, 0};
    do_run(8, 100, 0, 16'h1021, 1'b0);

    // Stalls with ignored start pulses.
    vpat = '{1, 0, 0, 1, 1};
    do_run(3, 100, 1, 0, 1'b1);

    // Empty run: straight to CHECK, golden equal to seed.
    do_run(0, 100, 0, 16'h0000, 1'b0);

`ifdef MISR_XMASK_EN
    mask_v = 10'h3FF;
    vpat = '{1}; dq = '{16'h3FF};
    do_run(1, 100, 0, 16'h0000, 1'b0);
    mask_v = 10'h0F0;
    do_run(6, 70, 1, 0, 1'b0);
    mask_v = '0;
`endif

    // Randomized runs with random gaps and ignored starts.
    for (int i = 0; i < 10; i++) begin
      do_run(int'($urandom_range(0, 20)), int'($urandom_range(30, 100)), 1, 0, 1'b1);
    end

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    start = 1'b1; num_patterns = 16'd5;
    @(negedge clk);
    start = 1'b0; resp_valid = 1'b1; resp = 10'h155;
    @(negedge clk);
    resp = 10'h0AA;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_sig", signature, 32'h0);
    chk("arst_cnt", count, 32'h0);
    chk("arst_ready", resp_ready, 32'h0);
    chk("arst_busy", busy, 32'h0);
    chk("arst_done", done, 32'h0);
    chk("arst_pass", pass, 32'h0);
    resp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", resp_ready, 32'h0);
    chk("post_rst_busy", busy, 32'h0);

    // A passing run, then reset asynchronously while done/pass are high.
    vpat = '{1}; dq = '{5};
    do_run(1, 100, 0, 16'h0005, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_done_pass", pass, 32'h0);
    chk("arst_done_done", done, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_run(4, 60, 1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
